// File: rtl/pattern_busy_sched_pkg.sv
// ============================================================================
// Module   : pattern_busy_sched_pkg
// Purpose  : Shared pattern parameters: sorter widths, scheduler defaults and
//            the scheduler FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pattern_busy_sched_pkg;

    localparam int DEF_NSEG   = 7;
    localparam int DEF_MXDLYB = 4;
    localparam int DEF_MXCNTB = 16;

    // Best-of-7 sorter key layout; the segment index sits in the top bits.
    localparam int SORT_SEG_W = 3;
    localparam int SORT_KEY_W = 11;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pattern_busy_timer.sv
// ============================================================================
// Module   : pattern_busy_timer
// Purpose  : Single busy-hold down-counter with load and clear (clear wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_busy_timer #(
    parameter int MXDLYB = 4
) (
    input  logic              clock,
    input  logic              global_reset_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [MXDLYB-1:0] load_val_i,
    output logic              busy_o,
    output logic              busy_next_o
);

    logic [MXDLYB-1:0] cnt_q;
    logic [MXDLYB-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o      = (cnt_q != '0);
    assign busy_next_o = (cnt_d != '0);

endmodule

`default_nettype wire

// File: rtl/pattern_busy_sched.sv
// ============================================================================
// Module   : pattern_busy_sched
// Purpose  : Per-segment busy scheduler for the best-of-7 pattern sorter.
//            Optional macro PATTERN_ADJ_BLANK_EN also blanks neighbour segments.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_busy_sched
    import pattern_busy_sched_pkg::*;
#(
    parameter int NSEG   = DEF_NSEG,
    parameter int MXDLYB = DEF_MXDLYB,
    parameter int MXCNTB = DEF_MXCNTB
) (
    input  logic              clock,
    input  logic              global_reset_n,
    input  logic              best_vld,
    input  logic [2:0]        best_seg,
    input  logic              best_bsy,
    input  logic [NSEG-1:0]   any_hit,
    input  logic [MXDLYB-1:0] hold_dly,
    input  logic              flush_req,
    input  logic              cnt_clr,
    output logic [NSEG-1:0]   bsy,
    output logic [2:0]        nbusy,
    output logic [MXCNTB-1:0] drop_cnt,
    output logic              seg_err
);

    logic [0:0]        state_q, state_d;
    logic [MXDLYB-1:0] flush_cnt_q, flush_cnt_d;
    logic [NSEG-1:0]   bsy_q, bsy_d;
    logic [2:0]        nbusy_q, nbusy_d;
    logic [MXCNTB-1:0] drop_q, drop_d;
    logic              seg_err_q, seg_err_d;

    logic              w_seg_ok;
    logic              w_accept;
    logic [NSEG-1:0]   w_load;
    logic [NSEG-1:0]   w_busy;
    logic [NSEG-1:0]   w_busy_next;

    assign w_seg_ok = (int'(best_seg) < NSEG);
    assign w_accept = best_vld && !best_bsy && w_seg_ok && (state_q == ST_RUN);

    always_comb begin
        w_load = '0;
        for (int s = 0; s < NSEG; s++) begin
            w_load[s] = w_accept && (int'(best_seg) == s);
`ifdef PATTERN_ADJ_BLANK_EN
            // s-1 never matches for s=0 and s+1=NSEG is never accepted: no wrap.
            w_load[s] = w_load[s] ||
                        (w_accept && ((int'(best_seg) == s - 1) || (int'(best_seg) == s + 1)));
`endif
        end
    end

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        pattern_busy_timer #(
            .MXDLYB (MXDLYB)
        ) u_timer (
            .clock          (clock),
            .global_reset_n (global_reset_n),
            .clear_i        (flush_req),
            .load_i         (w_load[g]),
            .load_val_i     (hold_dly),
            .busy_o         (w_busy[g]),
            .busy_next_o    (w_busy_next[g])
        );
    end

    // FSM: state register
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // FSM: next state, flush counter included
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    flush_cnt_d = hold_dly;
                    if (hold_dly != '0) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_req) begin
                    flush_cnt_d = hold_dly;
                    if (hold_dly == '0) begin
                        state_d = ST_RUN;
                    end
                end else if (flush_cnt_q <= 1) begin
                    flush_cnt_d = '0;
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    // FSM: outputs; nbusy is derived from the same next value as bsy
    always_comb begin
        bsy_d   = (state_d == ST_FLUSH) ? {NSEG{1'b1}} : w_busy_next;
        nbusy_d = '0;
        for (int i = 0; i < NSEG; i++) begin
            nbusy_d = nbusy_d + {2'b00, bsy_d[i]};
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (cnt_clr) begin
            drop_d = '0;
        end else if (best_bsy && (|any_hit) && (drop_q != {MXCNTB{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
        seg_err_d = seg_err_q;
        if (cnt_clr) begin
            seg_err_d = 1'b0;
        end else if (best_vld && !w_seg_ok) begin
            seg_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            bsy_q     <= '0;
            nbusy_q   <= '0;
            drop_q    <= '0;
            seg_err_q <= 1'b0;
        end else begin
            bsy_q     <= bsy_d;
            nbusy_q   <= nbusy_d;
            drop_q    <= drop_d;
            seg_err_q <= seg_err_d;
        end
    end

    assign bsy      = bsy_q;
    assign nbusy    = nbusy_q;
    assign drop_cnt = drop_q;
    assign seg_err  = seg_err_q;

endmodule

`default_nettype wire
